life_array_dumper: RTL and testbench

- Reader-side counterpart to the pattern controller that writes the 8x8 life array.
- On a start pulse it walks the array's quadrant read port (valo/valo_selector) and captures a consistent 64-cell snapshot.
- It then streams the snapshot as a byte frame over a valid/ready handshake, to a UART transmitter or debug FIFO.
- Sits beside the display path in the top level and shares the array's read port only while busy.

---
 rtl/life_array_dumper_if.sv | 10 +
 rtl/life_array_dumper.sv | 147 ++++++++++++++
 tb/tb_life_array_dumper.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/life_array_dumper_if.sv
// Byte-stream valid/ready link between the life array dumper and its sink
// (UART transmitter or debug FIFO).
interface life_array_dumper_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/life_array_dumper.sv
// Snapshots the 8x8 life array through its quadrant read port and streams it
// as a byte frame. Define LIFE_DUMP_POPCOUNT_EN to append a population count.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | waiting for i_start; read port left alone
// S_SELECT | selector driven to quad r_q, settle, then capture i_valo
// S_SEND   | one bubble cycle, then HEADER + snapshot bytes over tx handshake
module life_array_dumper #(
    parameter int         NUM_QUADS     = 4,
    parameter int         SETTLE_CYCLES = 1,
    parameter logic [7:0] HEADER        = 8'hA5
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic [15:0]                 i_valo,
    output logic [1:0]                  o_valo_selector,
    output logic                        o_busy,
    output logic                        o_done,
    life_array_dumper_if.master         tx
);

`ifdef LIFE_DUMP_POPCOUNT_EN
    localparam int FRAME_LEN = 2 * NUM_QUADS + 2;
`else
    localparam int FRAME_LEN = 2 * NUM_QUADS + 1;
`endif
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
    localparam logic [1:0]       LAST_QUAD = 2'(NUM_QUADS - 1);
    localparam logic [2:0]       SETTLE_TC = 3'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_SEND
    } state_t;

    state_t                     r_state;
    logic [1:0]                 r_q;
    logic [2:0]                 r_settle;
    logic [NUM_QUADS-1:0][15:0] r_snap;
    logic [IDX_W-1:0]           r_idx;
    logic [7:0]                 r_tx_data;
    logic                       r_tx_valid;
    logic                       r_busy;
    logic                       r_done;
    logic [1:0]                 r_sel;

    logic [IDX_W-1:0]           w_sel_idx;
    logic [7:0]                 w_byte;

    // Byte to load next: the current index during the bubble, else the one after.
    assign w_sel_idx = r_tx_valid ? (r_idx + 1'b1) : r_idx;

`ifdef LIFE_DUMP_POPCOUNT_EN
    logic [7:0] w_popcount;

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < NUM_QUADS; i++) begin
            for (int b = 0; b < 16; b++) begin
                w_popcount = w_popcount + {7'd0, r_snap[i][b]};
            end
        end
    end
`endif

    always_comb begin
        w_byte = HEADER;
        for (int i = 0; i < NUM_QUADS; i++) begin
            if (w_sel_idx == IDX_W'(2 * i + 1)) w_byte = r_snap[i][15:8];
            if (w_sel_idx == IDX_W'(2 * i + 2)) w_byte = r_snap[i][7:0];
        end
`ifdef LIFE_DUMP_POPCOUNT_EN
        if (w_sel_idx == IDX_W'(2 * NUM_QUADS + 1)) w_byte = w_popcount;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_q        <= '0;
            r_settle   <= '0;
            r_snap     <= '0;
            r_idx      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sel      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state  <= S_SELECT;
                        r_q      <= '0;
                        r_settle <= '0;
                        r_sel    <= '0;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                S_SELECT: begin
                    if (r_settle == SETTLE_TC) begin
                        r_snap[r_q] <= i_valo;
                        if (r_q == LAST_QUAD) begin
                            r_state <= S_SEND;
                        end else begin
                            r_q      <= r_q + 2'd1;
                            r_sel    <= r_q + 2'd1;
                            r_settle <= '0;
                        end
                    end else begin
                        r_settle <= r_settle + 3'd1;
                    end
                end
                S_SEND: begin
                    if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= w_byte;
                    end else if (tx.tx_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_tx_valid <= 1'b0;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_idx     <= r_idx + 1'b1;
                            r_tx_data <= w_byte;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_valo_selector = r_sel;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign tx.tx_data      = r_tx_data;
    assign tx.tx_valid     = r_tx_valid;

endmodule

// File: tb/tb_life_array_dumper.sv
// Directed bench for life_array_dumper: one default instance (SETTLE=1) and one
// with SETTLE_CYCLES=3 fed by an array model that only settles after 3 cycles.
module tb_life_array_dumper;

`ifdef LIFE_DUMP_POPCOUNT_EN
    localparam int FRAME_N = 10;
`else
    localparam int FRAME_N = 9;
`endif
    localparam logic [7:0] EXP_BASIC [0:9] =
        '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h20};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1 = 1'b0, start3 = 1'b0;
    logic [15:0] valo1, valo3;
    logic [1:0]  sel1, sel3;
    logic        busy1, busy3, done1, done3;

    life_array_dumper_if tx1 ();
    life_array_dumper_if tx3 ();

    always #5 clk = ~clk;

    life_array_dumper u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_valo(valo1),
        .o_valo_selector(sel1), .o_busy(busy1), .o_done(done1), .tx(tx1)
    );

    life_array_dumper #(.SETTLE_CYCLES(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .i_valo(valo3),
        .o_valo_selector(sel3), .o_busy(busy3), .o_done(done3), .tx(tx3)
    );

    logic [15:0] quads [0:3];
    assign valo1 = quads[sel1];

    // Slow array model: garbage until 3 cycles after the selector (or start) changes.
    logic [1:0] prev_sel3 = 2'd0;
    int         age3 = 0;
    logic       fresh3;
    assign fresh3 = (sel3 != prev_sel3);
    assign valo3  = (!fresh3 && age3 >= 3) ? 16'hFFFF : 16'h0000;
    always @(posedge clk) begin
        prev_sel3 <= sel3;
        if (start3)      age3 <= 0;
        else if (fresh3) age3 <= 1;
        else if (age3 < 7) age3 <= age3 + 1;
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] rx [0:15];
    logic [1:0] sel_log [0:31];
    int rx_n, done_n, done_c, busy_n, stall_err;
    bit timed_out, done_busy;

    task automatic collect(input bit which, input int ready_pct,
                           input int restart_at, input int tail);
        logic v, b, dn, r, s, pst;
        logic [7:0] d, pd;
        bit restarted;
        rx_n = 0; done_n = 0; done_c = -1; busy_n = 0; stall_err = 0;
        timed_out = 1; done_busy = 0; pst = 0; pd = 0; restarted = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            s = (c == 0) ||
                (restart_at >= 0 && !restarted && c > 0 && rx_n == restart_at);
            if (s && c > 0) restarted = 1;
            if (which) start3 = s; else start1 = s;
            v  = which ? tx3.tx_valid : tx1.tx_valid;
            d  = which ? tx3.tx_data  : tx1.tx_data;
            b  = which ? busy3 : busy1;
            dn = which ? done3 : done1;
            if (c < 32) sel_log[c] = which ? sel3 : sel1;
            if (b) busy_n++;
            if (dn) begin
                done_n++;
                if (done_c < 0) begin
                    done_c = c;
                    done_busy = b;
                end
            end
            if (pst && (!v || d !== pd)) stall_err++;
            r = ($urandom_range(0, 99) < ready_pct);
            if (which) tx3.tx_ready = r; else tx1.tx_ready = r;
            if (v && r && rx_n < 16) begin
                rx[rx_n] = d;
                rx_n++;
            end
            pst = v && !r;
            pd  = d;
            if (done_c >= 0 && c >= done_c + tail) begin
                timed_out = 0;
                break;
            end
        end
        start1 = 0; start3 = 0;
        tx1.tx_ready = 0; tx3.tx_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx1.tx_valid, busy1, done1, sel1, tx1.tx_data} !== 13'd0) begin
            errors++;
            $display("FAIL reset_dut1: got valid=%b busy=%b done=%b sel=%0d data=%h expected all 0",
                     tx1.tx_valid, busy1, done1, sel1, tx1.tx_data);
        end
        checks++;
        if ({tx3.tx_valid, busy3, done3, sel3, tx3.tx_data} !== 13'd0) begin
            errors++;
            $display("FAIL reset_dut3: got valid=%b busy=%b done=%b sel=%0d data=%h expected all 0",
                     tx3.tx_valid, busy3, done3, sel3, tx3.tx_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        quads[0] = 16'h1234; quads[1] = 16'h5678;
        quads[2] = 16'h9ABC; quads[3] = 16'hDEF0;
        collect(0, 100, -1, 3);
        checks++;
        if (timed_out || rx_n !== FRAME_N) begin
            errors++;
            $display("FAIL basic_len: got %0d bytes (timeout=%0d) expected %0d", rx_n, timed_out, FRAME_N);
        end
        for (int i = 0; i < FRAME_N; i++) begin
            checks++;
            if (rx[i] !== EXP_BASIC[i]) begin
                errors++;
                $display("FAIL basic_byte[%0d]: got %h expected %h", i, rx[i], EXP_BASIC[i]);
            end
        end
        checks++;
        if (done_n !== 1 || done_c !== FRAME_N + 10) begin
            errors++;
            $display("FAIL basic_done: got %0d pulses at cycle %0d expected 1 at cycle %0d",
                     done_n, done_c, FRAME_N + 10);
        end
        checks++;
        if (busy_n !== FRAME_N + 9 || done_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: got %0d busy cycles, busy_at_done=%b expected %0d and 0",
                     busy_n, done_busy, FRAME_N + 9);
        end
        checks++;
        if (sel1 !== 2'd3) begin
            errors++;
            $display("FAIL basic_sel_hold: got %0d expected 3", sel1);
        end
    endtask

    task automatic test_backpressure();
        collect(0, 30, -1, 2);
        checks++;
        if (timed_out || rx_n !== FRAME_N) begin
            errors++;
            $display("FAIL bp_len: got %0d bytes (timeout=%0d) expected %0d", rx_n, timed_out, FRAME_N);
        end
        for (int i = 0; i < FRAME_N; i++) begin
            checks++;
            if (rx[i] !== EXP_BASIC[i]) begin
                errors++;
                $display("FAIL bp_byte[%0d]: got %h expected %h", i, rx[i], EXP_BASIC[i]);
            end
        end
        checks++;
        if (stall_err !== 0 || done_n !== 1) begin
            errors++;
            $display("FAIL bp_stall: got %0d unstable stalls, %0d done pulses expected 0 and 1",
                     stall_err, done_n);
        end
    endtask

    task automatic test_start_while_busy();
        collect(0, 100, 3, 30);
        checks++;
        if (timed_out || rx_n !== FRAME_N || done_n !== 1) begin
            errors++;
            $display("FAIL busy_start: got %0d bytes %0d done pulses (timeout=%0d) expected %0d and 1",
                     rx_n, done_n, timed_out, FRAME_N);
        end
        checks++;
        if (rx[0] !== 8'hA5 || rx[FRAME_N-1] !== EXP_BASIC[FRAME_N-1]) begin
            errors++;
            $display("FAIL busy_start_bytes: got first %h last %h expected A5 and %h",
                     rx[0], rx[FRAME_N-1], EXP_BASIC[FRAME_N-1]);
        end
    endtask

    task automatic test_capture_timing();
        collect(1, 100, -1, 0);
        checks++;
        if (timed_out || rx_n !== FRAME_N || done_c !== FRAME_N + 18) begin
            errors++;
            $display("FAIL cap_len: got %0d bytes done at %0d (timeout=%0d) expected %0d at %0d",
                     rx_n, done_c, timed_out, FRAME_N, FRAME_N + 18);
        end
        checks++;
        if (rx[0] !== 8'hA5) begin
            errors++;
            $display("FAIL cap_header: got %h expected a5", rx[0]);
        end
        for (int i = 1; i < 9; i++) begin
            checks++;
            if (rx[i] !== 8'hFF) begin
                errors++;
                $display("FAIL cap_byte[%0d]: got %h expected ff", i, rx[i]);
            end
        end
`ifdef LIFE_DUMP_POPCOUNT_EN
        checks++;
        if (rx[9] !== 8'h40) begin
            errors++;
            $display("FAIL cap_popcount: got %h expected 40", rx[9]);
        end
`endif
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (sel_log[c] !== 2'((c - 1) / 4)) begin
                errors++;
                $display("FAIL cap_sel[%0d]: got %0d expected %0d", c, sel_log[c], (c - 1) / 4);
            end
        end
    endtask

    task automatic test_reset_mid_send();
        int n;
        n = 0;
        tx1.tx_ready = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int c = 0; c < 100 && n < 4; c++) begin
            @(negedge clk);
            if (tx1.tx_valid) n++;
        end
        @(posedge clk);
        #2;
        checks++;
        if (n !== 4 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_setup: got %0d bytes busy=%b expected 4 and 1", n, busy1);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx1.tx_valid, busy1, done1, sel1} !== 5'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got valid=%b busy=%b done=%b sel=%0d expected all 0",
                     tx1.tx_valid, busy1, done1, sel1);
        end
        tx1.tx_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        collect(0, 100, -1, 0);
        checks++;
        if (timed_out || rx_n !== FRAME_N) begin
            errors++;
            $display("FAIL rst_mid_len: got %0d bytes (timeout=%0d) expected %0d", rx_n, timed_out, FRAME_N);
        end
        for (int i = 0; i < FRAME_N; i++) begin
            checks++;
            if (rx[i] !== EXP_BASIC[i]) begin
                errors++;
                $display("FAIL rst_mid_byte[%0d]: got %h expected %h", i, rx[i], EXP_BASIC[i]);
            end
        end
    endtask

`ifdef LIFE_DUMP_POPCOUNT_EN
    task automatic test_popcount();
        quads[0] = 16'hFFFF; quads[1] = 16'h0001;
        quads[2] = 16'h0000; quads[3] = 16'h8000;
        collect(0, 100, -1, 0);
        checks++;
        if (timed_out || rx_n !== 10 || rx[9] !== 8'h12) begin
            errors++;
            $display("FAIL popcount_mixed: got %0d bytes last %h expected 10 and 12", rx_n, rx[9]);
        end
        quads[1] = 16'hFFFF; quads[2] = 16'hFFFF; quads[3] = 16'hFFFF;
        collect(0, 100, -1, 0);
        checks++;
        if (timed_out || rx_n !== 10 || rx[9] !== 8'h40) begin
            errors++;
            $display("FAIL popcount_ones: got %0d bytes last %h expected 10 and 40", rx_n, rx[9]);
        end
    endtask
`endif

    initial begin
        tx1.tx_ready = 1'b0;
        tx3.tx_ready = 1'b0;
        quads[0] = 16'h0; quads[1] = 16'h0; quads[2] = 16'h0; quads[3] = 16'h0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_start_while_busy();
        test_capture_timing();
        test_reset_mid_send();
`ifdef LIFE_DUMP_POPCOUNT_EN
        test_popcount();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
